// File: rtl/axi_slave_rd.sv
// AXI read-side memory slave: one AR at a time, burst served from a 1-cycle-latency word RAM.
// Optional macro WRAP_BURST_EN enables WRAP decoding; without it burst 2'b10 is answered as reserved.
module axi_slave_rd #(
  parameter int unsigned ADDR_BITS = 32,
  parameter int unsigned DATA_BITS = 32,
  parameter int unsigned LEN_BITS  = 8,
  parameter int unsigned SIZE_BITS = 3,
  parameter int unsigned MEM_DEPTH = 1024,
  localparam int unsigned AW       = $clog2(MEM_DEPTH)
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic                 ar_valid,
  output logic                 ar_ready,
  input  logic [ADDR_BITS-1:0] ar_addr,
  input  logic [LEN_BITS-1:0]  ar_len,
  input  logic [SIZE_BITS-1:0] ar_size,
  input  logic [1:0]           ar_burst,
  input  logic [3:0]           ar_cache,
  output logic                 r_valid,
  input  logic                 r_ready,
  output logic [DATA_BITS-1:0] r_data,
  output logic                 r_last,
  output logic [1:0]           r_resp,
  output logic                 rd_en,
  output logic [AW-1:0]        rd_addr,
  input  logic [DATA_BITS-1:0] rd_data
);

  localparam int unsigned LANE_BITS = $clog2(DATA_BITS / 8);

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DATA
  } state_t;

  state_t               state;
  logic [ADDR_BITS-1:0] addr_q;
  logic [ADDR_BITS-1:0] next_addr;
  logic [ADDR_BITS-1:0] step;
  logic [LEN_BITS-1:0]  len_q;
  logic [LEN_BITS-1:0]  cnt_q;
  logic [SIZE_BITS-1:0] size_q;
  logic [1:0]           burst_q;
  logic                 req_err_q;
  logic                 beat_err_q;
  logic                 req_err_c;
  logic                 wrap_err_c;
  logic                 next_err_c;
  logic                 beat_hs_c;
  logic                 unused_c;

  // Word index past the end of the RAM; evaluated on the full byte address.
  function automatic logic out_of_range(input logic [ADDR_BITS-1:0] a);
    return (a >> LANE_BITS) >= ADDR_BITS'(MEM_DEPTH);
  endfunction

  assign step = ADDR_BITS'(1) << size_q;

`ifdef WRAP_BURST_EN
  logic [ADDR_BITS-1:0] ar_step;
  logic [ADDR_BITS-1:0] wrap_mask;
  logic                 wrap_len_ok;

  assign ar_step     = ADDR_BITS'(1) << ar_size;
  assign wrap_mask   = ((ADDR_BITS'(len_q) + ADDR_BITS'(1)) << size_q) - ADDR_BITS'(1);
  assign wrap_len_ok = (ar_len == LEN_BITS'(1)) || (ar_len == LEN_BITS'(3)) ||
                       (ar_len == LEN_BITS'(7)) || (ar_len == LEN_BITS'(15));
  assign wrap_err_c  = (ar_burst == BURST_WRAP) &&
                       (!wrap_len_ok || ((ar_addr & (ar_step - ADDR_BITS'(1))) != '0));
`else
  assign wrap_err_c  = (ar_burst == BURST_WRAP);
`endif

  assign req_err_c = (ar_size > SIZE_BITS'(LANE_BITS)) || (ar_burst == BURST_RSVD) || wrap_err_c;

  // Address of the following beat; reserved bursts keep FIXED addressing.
  always_comb begin
    next_addr = addr_q;
    case (burst_q)
      BURST_INCR: next_addr = addr_q + step;
`ifdef WRAP_BURST_EN
      BURST_WRAP: next_addr = (addr_q & ~wrap_mask) | ((addr_q + step) & wrap_mask);
`endif
      default:    next_addr = addr_q;
    endcase
  end

  assign beat_hs_c  = (state == DATA) && r_valid && r_ready;
  assign next_err_c = req_err_q || out_of_range(next_addr);

  // Next beat is fetched during the current handshake so data streams one beat per cycle.
  assign rd_en   = ((state == FETCH) && !beat_err_q) ||
                   (beat_hs_c && !r_last && !next_err_c);
  assign rd_addr = AW'(((state == DATA) ? next_addr : addr_q) >> LANE_BITS);
  assign r_data  = beat_err_q ? '0 : rd_data;

  assign unused_c = ^{ar_cache, len_q};

  always_ff @(posedge aclk) begin
    if (areset) begin
      state      <= IDLE;
      ar_ready   <= 1'b1;
      r_valid    <= 1'b0;
      r_last     <= 1'b0;
      r_resp     <= RESP_OKAY;
      addr_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      size_q     <= '0;
      burst_q    <= '0;
      req_err_q  <= 1'b0;
      beat_err_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ar_valid && ar_ready) begin
            addr_q     <= ar_addr;
            len_q      <= ar_len;
            cnt_q      <= ar_len;
            size_q     <= ar_size;
            burst_q    <= ar_burst;
            req_err_q  <= req_err_c;
            beat_err_q <= req_err_c || out_of_range(ar_addr);
            ar_ready   <= 1'b0;
            state      <= FETCH;
          end
        end
        FETCH: begin
          r_valid <= 1'b1;
          r_last  <= (cnt_q == '0);
          r_resp  <= beat_err_q ? RESP_SLVERR : RESP_OKAY;
          state   <= DATA;
        end
        DATA: begin
          if (r_ready) begin
            if (r_last) begin
              r_valid  <= 1'b0;
              r_last   <= 1'b0;
              r_resp   <= RESP_OKAY;
              ar_ready <= 1'b1;
              state    <= IDLE;
            end else begin
              cnt_q      <= cnt_q - LEN_BITS'(1);
              addr_q     <= next_addr;
              beat_err_q <= next_err_c;
              r_last     <= (cnt_q == LEN_BITS'(1));
              r_resp     <= next_err_c ? RESP_SLVERR : RESP_OKAY;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_slave_rd.sv
// Bench for axi_slave_rd: directed table, corner sequences and random bursts vs a beat-list model.
module tb_axi_slave_rd;

  localparam int unsigned DEPTH = 1024;

`ifdef WRAP_BURST_EN
  localparam bit WRAP_ON = 1'b1;
`else
  localparam bit WRAP_ON = 1'b0;
`endif

  logic        aclk = 1'b0;
  logic        areset;
  logic        ar_valid;
  logic        ar_ready;
  logic [31:0] ar_addr;
  logic [7:0]  ar_len;
  logic [2:0]  ar_size;
  logic [1:0]  ar_burst;
  logic [3:0]  ar_cache;
  logic        r_valid;
  logic        r_ready;
  logic [31:0] r_data;
  logic        r_last;
  logic [1:0]  r_resp;
  logic        rd_en;
  logic [9:0]  rd_addr;
  logic [31:0] rd_data;

  logic [31:0] mem [DEPTH];
  int total = 0;
  int bad = 0;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    int          rmode;
    int          exp_ok;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic        err;
  } beat_t;

  beat_t exp_q[$];
  vec_t  vecs[12];

  axi_slave_rd dut (
    .aclk(aclk), .areset(areset),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_len(ar_len),
    .ar_size(ar_size), .ar_burst(ar_burst), .ar_cache(ar_cache),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_last(r_last), .r_resp(r_resp),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 aclk = ~aclk;

  // Synchronous RAM, one cycle of read latency, output held between strobes.
  always @(posedge aclk) if (rd_en) rd_data <= mem[rd_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", name, act, exp_v, $time);
    end
  endtask

  // Expected beat list: address of every beat and whether it must be an error beat.
  function automatic void build_model(input logic [31:0] a, input logic [7:0] l,
                                      input logic [2:0] s, input logic [1:0] b);
    longint la, stp, ad;
    bit     req_err;
    beat_t  bt;
`ifdef WRAP_BURST_EN
    longint bound, base;
`endif
    exp_q.delete();
    la      = longint'(a);
    stp     = longint'(1) << s;
    req_err = (s > 3'd2) || (b == 2'b11);
`ifdef WRAP_BURST_EN
    bound = (longint'(l) + 1) * stp;
    base  = la - (la % bound);
    if (b == 2'b10)
      req_err = req_err || !(l inside {8'd1, 8'd3, 8'd7, 8'd15}) || ((la % stp) != 0);
`else
    if (b == 2'b10) req_err = 1'b1;
`endif
    for (int i = 0; i <= int'(l); i++) begin
      if (b == 2'b01) ad = (la + longint'(i) * stp) % 64'h1_0000_0000;
`ifdef WRAP_BURST_EN
      else if (b == 2'b10) ad = base + ((la - base + longint'(i) * stp) % bound);
`endif
      else ad = la;
      bt.addr = ad[31:0];
      bt.err  = req_err || ((ad >> 2) >= longint'(DEPTH));
      exp_q.push_back(bt);
    end
  endfunction

  task automatic do_burst(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                          input logic [1:0] b, input int rmode, output int n_ok);
    int    nb, i, cyc, rd_cnt, exp_rd;
    bit    nxt_rd;
    beat_t bt;
    build_model(a, l, s, b);
    nb = exp_q.size();
    n_ok = 0; rd_cnt = 0; exp_rd = 0;
    foreach (exp_q[k]) if (!exp_q[k].err) exp_rd++;
    @(posedge aclk); #1;
    ar_valid = 1'b1; ar_addr = a; ar_len = l; ar_size = s; ar_burst = b;
    ar_cache = 4'($urandom);
    @(negedge aclk);
    chk("ar_ready_idle", 32'(ar_ready), 32'd1);
    @(posedge aclk); #1;
    ar_valid = 1'b0; ar_addr = $urandom; ar_len = 8'($urandom); ar_burst = 2'($urandom);
    @(negedge aclk);
    chk("ar_ready_busy", 32'(ar_ready), 32'd0);
    chk("r_valid_fetch", 32'(r_valid), 32'd0);
    chk("rd_en_fetch", 32'(rd_en), 32'(!exp_q[0].err));
    if (rd_en) rd_cnt++;
    if (!exp_q[0].err) chk("rd_addr_fetch", 32'(rd_addr), exp_q[0].addr >> 2);
    i = 0; cyc = 0;
    while (i < nb && cyc < 8 * nb + 64) begin
      @(posedge aclk); #1;
      case (rmode)
        0:       r_ready = 1'b1;
        1:       r_ready = (cyc % 3 == 0);
        default: r_ready = 1'($urandom_range(0, 1));
      endcase
      @(negedge aclk);
      if (rd_en) rd_cnt++;
      if (!r_valid) begin
        chk("r_valid_beat", 32'(r_valid), 32'd1);
        break;
      end
      bt = exp_q[i];
      if (bt.err) chk("r_data_err", r_data, 32'd0);
      else        chk("r_data", r_data, mem[bt.addr >> 2]);
      chk("r_resp", 32'(r_resp), bt.err ? 32'd2 : 32'd0);
      chk("r_last", 32'(r_last), 32'(i == nb - 1));
      if (r_ready) begin
        nxt_rd = (i < nb - 1) ? !exp_q[i + 1].err : 1'b0;
        chk("rd_en_beat", 32'(rd_en), 32'(nxt_rd));
        if (nxt_rd) chk("rd_addr_beat", 32'(rd_addr), exp_q[i + 1].addr >> 2);
        if (r_resp == 2'b00) n_ok++;
        i++;
      end else begin
        chk("rd_en_stall", 32'(rd_en), 32'd0);
      end
      cyc++;
    end
    if (i < nb) chk("burst_beats_timeout", 32'(i), 32'(nb));
    @(posedge aclk); #1;
    r_ready = 1'b0;
    @(negedge aclk);
    chk("r_valid_after", 32'(r_valid), 32'd0);
    chk("ar_ready_after", 32'(ar_ready), 32'd1);
    chk("rd_en_count", 32'(rd_cnt), 32'(exp_rd));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n_ok;
    logic [31:0] a;
    logic [7:0]  l;
    logic [2:0]  s;
    logic [1:0]  b;

    for (int i = 0; i < int'(DEPTH); i++) mem[i] = (i < 4) ? 32'hA0 + 32'(i) : $urandom;

    vecs[0]  = '{32'h0,   8'd0,   3'd2, 2'b01, 0, 4};
    vecs[0].len = 8'd3;
    vecs[1]  = '{32'h8,   8'd3,   3'd2, 2'b10, 0, WRAP_ON ? 4 : 0};
    vecs[2]  = '{32'h10,  8'd2,   3'd2, 2'b00, 1, 3};
    vecs[3]  = '{32'hFF8, 8'd3,   3'd2, 2'b01, 0, 2};
    vecs[4]  = '{32'h0,   8'd0,   3'd2, 2'b11, 0, 0};
    vecs[5]  = '{32'h0,   8'd0,   3'd2, 2'b01, 1, 1};
    vecs[6]  = '{32'h100, 8'd255, 3'd2, 2'b01, 0, 256};
    vecs[7]  = '{32'h0,   8'd1,   3'd3, 2'b01, 0, 0};
    vecs[8]  = '{32'h0,   8'd2,   3'd2, 2'b10, 0, 0};
    vecs[9]  = '{32'h6,   8'd1,   3'd2, 2'b10, 0, 0};
    vecs[10] = '{32'h3,   8'd5,   3'd0, 2'b01, 1, 6};
    vecs[11] = '{32'h1E,  8'd7,   3'd1, 2'b10, 2, WRAP_ON ? 8 : 0};

    areset = 1'b1; ar_valid = 1'b0; ar_addr = '0; ar_len = '0; ar_size = '0;
    ar_burst = '0; ar_cache = '0; r_ready = 1'b0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("rst_ar_ready", 32'(ar_ready), 32'd1);
    chk("rst_r_valid", 32'(r_valid), 32'd0);
    chk("rst_r_last", 32'(r_last), 32'd0);
    chk("rst_r_resp", 32'(r_resp), 32'd0);
    chk("rst_rd_en", 32'(rd_en), 32'd0);
    chk("rst_rd_addr", 32'(rd_addr), 32'd0);
    @(posedge aclk); #1;
    areset = 1'b0;

    foreach (vecs[k]) begin
      do_burst(vecs[k].addr, vecs[k].len, vecs[k].size, vecs[k].burst, vecs[k].rmode, n_ok);
      chk($sformatf("ok_beats_vec%0d", k), 32'(n_ok), 32'(vecs[k].exp_ok));
    end

    // Reserved burst, held stalled, with a second AR waiting behind it.
    @(posedge aclk); #1;
    ar_valid = 1'b1; ar_addr = 32'h0; ar_len = 8'd0; ar_size = 3'd2; ar_burst = 2'b11;
    @(negedge aclk);
    chk("busy_ar_ready0", 32'(ar_ready), 32'd1);
    @(posedge aclk); #1;
    ar_addr = 32'h4; ar_burst = 2'b01;
    @(negedge aclk);
    chk("busy_ar_ready_fetch", 32'(ar_ready), 32'd0);
    repeat (3) begin
      @(posedge aclk); #1;
      @(negedge aclk);
      chk("busy_ar_ready", 32'(ar_ready), 32'd0);
      chk("busy_r_valid", 32'(r_valid), 32'd1);
      chk("busy_r_resp", 32'(r_resp), 32'd2);
      chk("busy_r_last", 32'(r_last), 32'd1);
      chk("busy_r_data", r_data, 32'd0);
      chk("busy_rd_en", 32'(rd_en), 32'd0);
    end
    @(posedge aclk); #1;
    r_ready = 1'b1;
    @(negedge aclk);
    chk("busy_hs_valid", 32'(r_valid), 32'd1);
    @(posedge aclk); #1;
    r_ready = 1'b0;
    @(negedge aclk);
    chk("busy_done_valid", 32'(r_valid), 32'd0);
    chk("busy_done_ready", 32'(ar_ready), 32'd1);
    @(posedge aclk); #1;
    ar_valid = 1'b0;
    @(negedge aclk);
    chk("second_ar_ready", 32'(ar_ready), 32'd0);
    chk("second_rd_en", 32'(rd_en), 32'd1);
    chk("second_rd_addr", 32'(rd_addr), 32'd1);
    @(posedge aclk); #1;
    r_ready = 1'b1;
    @(negedge aclk);
    chk("second_r_valid", 32'(r_valid), 32'd1);
    chk("second_r_data", r_data, mem[1]);
    chk("second_r_resp", 32'(r_resp), 32'd0);
    chk("second_r_last", 32'(r_last), 32'd1);
    @(posedge aclk); #1;
    r_ready = 1'b0;
    @(negedge aclk);
    chk("second_done_valid", 32'(r_valid), 32'd0);
    chk("second_done_ready", 32'(ar_ready), 32'd1);

    // Reset during beat 2 of an 8-beat burst, then a fresh single-beat read.
    @(posedge aclk); #1;
    ar_valid = 1'b1; ar_addr = 32'h0; ar_len = 8'd7; ar_size = 3'd2; ar_burst = 2'b01;
    r_ready = 1'b1;
    @(posedge aclk); #1;
    ar_valid = 1'b0;
    @(posedge aclk); #1;
    @(posedge aclk); #1;
    @(posedge aclk); #1;
    areset = 1'b1;
    @(negedge aclk);
    chk("rst_mid_beat2_data", r_data, mem[2]);
    @(posedge aclk); #1;
    areset = 1'b0; r_ready = 1'b0;
    @(negedge aclk);
    chk("rst_mid_r_valid", 32'(r_valid), 32'd0);
    chk("rst_mid_ar_ready", 32'(ar_ready), 32'd1);
    chk("rst_mid_rd_en", 32'(rd_en), 32'd0);
    chk("rst_mid_r_last", 32'(r_last), 32'd0);
    do_burst(32'hC, 8'd0, 3'd2, 2'b01, 0, n_ok);
    chk("rst_mid_next_ok", 32'(n_ok), 32'd1);

    // Random bursts against the model.
    for (int k = 0; k < 40; k++) begin
      a = 32'($urandom_range(0, 32'h1100));
      b = 2'($urandom_range(0, 3));
      s = 3'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) l = 8'($urandom_range(0, 15));
      else l = 8'((2 << $urandom_range(0, 3)) - 1);
      if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << s) - 32'd1);
      do_burst(a, l, s, b, 2, n_ok);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
